// File: rtl/axi3_slave_mem.sv
// rtl/axi3_slave_mem.sv - AXI3 memory slave with independent read/write burst engines
module axi3_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ID_WIDTH-1:0]     WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0]            SIZE_L  = 3'(BYTE_SH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] start_word(input logic [ADDR_WIDTH-1:0] addr);
        return addr >> BYTE_SH;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] len_ext(input logic [3:0] len);
        return {{(ADDR_WIDTH-4){1'b0}}, len};
    endfunction

    // Bursts are tracked as word indices; a WRAP window is LEN+1 words, LEN+1 a power of two.
    function automatic logic [ADDR_WIDTH-1:0] next_word(input logic [ADDR_WIDTH-1:0] word,
                                                        input logic [3:0] len,
                                                        input logic [1:0] burst);
        case (burst)
            2'b01:   return word + ADDR_WIDTH'(1);
            2'b10:   return (word & ~len_ext(len)) | ((word + ADDR_WIDTH'(1)) & len_ext(len));
            default: return word;
        endcase
    endfunction

    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [3:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH:0] first;
        logic [ADDR_WIDTH:0] last;
        first = {1'b0, start_word(addr)};
        case (burst)
            2'b01:   last = first + {1'b0, len_ext(len)};
            2'b10:   last = (first & ~{1'b0, len_ext(len)}) + {1'b0, len_ext(len)};
            default: last = first;
        endcase
        return (burst == 2'b11)
            || (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
            || (size != SIZE_L)
            || (last >= DEPTH_L);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [ADDR_WIDTH-1:0] w_word_q;
    logic [3:0]            w_len_q, w_cnt_q;
    logic [1:0]            w_burst_q, b_resp_q;
    logic                  w_err_q, w_lerr_q;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [ADDR_WIDTH-1:0] r_word_q;
    logic [3:0]            r_len_q, r_cnt_q;
    logic [1:0]            r_burst_q, r_resp_q;
    logic                  r_err_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    logic aw_hs, w_hs, w_last, ar_hs, r_hs, r_last, ar_err, fetch_err;
    logic [ADDR_WIDTH-1:0] fetch_word;
    logic unused_wid;

    assign aw_hs      = AWVALID && AWREADY;
    assign w_hs       = WVALID && WREADY;
    assign w_last     = (w_cnt_q == w_len_q);
    assign ar_hs      = ARVALID && ARREADY;
    assign r_hs       = RVALID && RREADY;
    assign r_last     = (r_cnt_q == r_len_q);
    assign ar_err     = burst_err(ARADDR, ARLEN, ARSIZE, ARBURST);
    assign fetch_word = ar_hs ? start_word(ARADDR) : next_word(r_word_q, r_len_q, r_burst_q);
    assign fetch_err  = ar_hs ? ar_err : r_err_q;
    assign unused_wid = ^WID;

    always_ff @(posedge ACLK) begin
        if (ARESET) w_state_q <= W_IDLE;
        else        w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last) w_state_d = W_RESP;
            W_RESP:  if (BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = (w_state_q == W_IDLE) && !ARESET;
        WREADY  = (w_state_q == W_DATA);
        BVALID  = (w_state_q == W_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_id_q    <= '0;
            w_word_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            w_lerr_q  <= 1'b0;
            b_resp_q  <= '0;
        end else begin
            if (aw_hs) begin
                w_id_q    <= AWID;
                w_word_q  <= start_word(AWADDR);
                w_len_q   <= AWLEN;
                w_burst_q <= AWBURST;
                w_cnt_q   <= '0;
                w_err_q   <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
                w_lerr_q  <= 1'b0;
            end
            // WLAST is only checked against the beat count, never used to end the burst.
            if (w_hs) begin
                w_cnt_q  <= w_cnt_q + 4'd1;
                w_word_q <= next_word(w_word_q, w_len_q, w_burst_q);
                if (w_last)
                    b_resp_q <= (w_err_q || w_lerr_q || !WLAST) ? 2'b10 : 2'b00;
                else if (WLAST)
                    w_lerr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET && w_hs && !w_err_q) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem_q[w_word_q[IDX_W-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state_q <= R_IDLE;
        else        r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = (r_state_q == R_IDLE) && !ARESET;
        RVALID  = (r_state_q == R_DATA);
        RLAST   = (r_state_q == R_DATA) && r_last;
    end

    // Read data is registered from mem_q, so a same-cycle write to that word returns old data.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_id_q    <= '0;
            r_word_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
            r_resp_q  <= '0;
            r_data_q  <= '0;
        end else begin
            if (ar_hs) begin
                r_id_q    <= ARID;
                r_word_q  <= fetch_word;
                r_len_q   <= ARLEN;
                r_burst_q <= ARBURST;
                r_cnt_q   <= '0;
                r_err_q   <= ar_err;
                r_resp_q  <= ar_err ? 2'b10 : 2'b00;
            end else if (r_hs && !r_last) begin
                r_cnt_q  <= r_cnt_q + 4'd1;
                r_word_q <= fetch_word;
            end
            if (ar_hs || (r_hs && !r_last))
                r_data_q <= fetch_err ? '0 : mem_q[fetch_word[IDX_W-1:0]];
        end
    end

    assign BID   = w_id_q;
    assign BRESP = b_resp_q;
    assign RID   = r_id_q;
    assign RDATA = r_data_q;
    assign RRESP = r_resp_q;

endmodule

// File: doc/axi3_slave_mem.md
AXI3_SLAVE_MEM -- requirements
Module: axi3_slave_mem

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 32, address width.
- DATA_WIDTH, default 32, data width; allowed values 32, 64, 128.
- ID_WIDTH, default 4, transaction ID width.
- MEM_DEPTH, default 256, number of DATA_WIDTH-bit words.
REQ-002 Clock and reset SHALL be: ACLK input 1, clock; ARESET input 1, reset, synchronous and active-high.
REQ-003 The write-address channel SHALL be: AWID in ID_WIDTH; AWADDR in ADDR_WIDTH; AWLEN in 4; AWSIZE in 3; AWBURST in 2; AWVALID in 1; AWREADY out 1.
REQ-004 The write-data channel SHALL be: WID in ID_WIDTH; WDATA in DATA_WIDTH; WSTRB in DATA_WIDTH/8; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-005 The write-response channel SHALL be: BID out ID_WIDTH; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-006 The read-address channel SHALL be: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID in (widths as the AW equivalents); ARREADY out 1.
REQ-007 The read-data channel SHALL be: RID out ID_WIDTH; RDATA out DATA_WIDTH; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.

Function
REQ-008 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
REQ-009 Write FSM behaviour SHALL be:
- AWREADY=1 only in W_IDLE.
- AW handshake: latch ID/ADDR/LEN/BURST, go to W_DATA.
- WREADY=1 only in W_DATA; one beat per WVALID&WREADY cycle.
REQ-010 On acceptance of beat AWLEN+1, the write FSM SHALL go to W_RESP.
- BVALID=1 the next cycle, with BID equal to the latched AWID.
- Return to W_IDLE on BVALID&BREADY.
REQ-011 The read FSM SHALL have states R_IDLE and R_DATA.
- ARREADY=1 only in R_IDLE.
- First RVALID one cycle after the AR handshake.
- One beat per RVALID&RREADY cycle.
- RLAST=1 on beat ARLEN+1; return to R_IDLE on that handshake.
REQ-012 Read and write SHALL proceed concurrently and independently.
REQ-013 A read and a write to the same word in the same cycle SHALL return the old data on RDATA.
REQ-014 Beat address SHALL follow the burst type:
- FIXED (00): every beat at the start address.
- INCR (01): start address plus beat index times DATA_WIDTH/8.
- WRAP (10): wraps within a (LEN+1)*DATA_WIDTH/8-aligned window.
- Word index = address >> log2(DATA_WIDTH/8).
REQ-015 A write beat SHALL update only the byte lanes whose WSTRB bit is 1.
REQ-016 A burst SHALL be erroneous (response SLVERR, 2'b10) if any of the following holds:
- AxBURST=11.
- WRAP with LEN not in {1,3,7,15}.
- AxSIZE not equal to log2(DATA_WIDTH/8).
- Any beat word index >= MEM_DEPTH.
REQ-017 An erroneous write SHALL modify no memory and return BRESP=10.
REQ-018 An erroneous read SHALL return RDATA=0 and RRESP=10 on every beat.
REQ-019 WLAST SHALL not terminate a burst early; the beat count alone ends the burst.
REQ-020 A WLAST value that mismatches the beat count SHALL force BRESP=10; beats whose address is in range are still written.
REQ-021 WID SHALL be ignored.
REQ-022 A good burst SHALL respond OKAY (00).
REQ-023 While RVALID=1 and RREADY=0, RDATA, RID, RRESP and RLAST SHALL hold stable.
REQ-024 While BVALID=1 and BREADY=0, BID and BRESP SHALL hold stable.

Reset
REQ-025 While ARESET=1 at a rising ACLK, all of the following SHALL be 0 the next cycle: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, BID, RID, RDATA.
REQ-026 Both FSMs SHALL return to their idle states on reset.
REQ-027 AWREADY and ARREADY SHALL be 1 in the first cycle after ARESET deasserts.
REQ-028 Reset mid-burst SHALL abandon the burst with no response issued.
REQ-029 Memory contents SHALL not be reset; words written before reset keep their values.

Verification
REQ-030 The bench SHALL cover these directed scenarios (DATA_WIDTH=32, MEM_DEPTH=256):
- INCR write LEN=3 at 0x10, data 0xA0..0xA3 -> BRESP=00; INCR read of the same -> 0xA0..0xA3, RLAST only on beat 4.
- WRAP write LEN=3 at 0x18 -> words land at 0x18, 0x1C, 0x10, 0x14; readback matches.
- Word 0x20 = 0x00000000, write 0xFFFFFFFF with WSTRB=0101 -> readback 0x00FF00FF.
- Write LEN=1 at 0x400 -> BRESP=10, memory unchanged; read LEN=1 at 0x400 -> two beats RDATA=0, RRESP=10.
- ARESET=1 after 2 of 4 write beats -> BVALID never asserts; AWREADY=1 on the first cycle after release; first 2 words retain the written data.
- Read LEN=3 with RREADY low for 3 cycles on beat 2 -> RDATA/RLAST stable; total 4 beats delivered.
